// File: rtl/stretcher.sv
// stretcher: catches short asynchronous high pulses on inp and turns each
// captured event into a clk-synchronous pulse on q, STRETCH_CYCLES long.
// The capture flop is cleared by the last synchronizer stage. An inp edge
// that arrives while that clear is active is dropped.
// Optional macro STRETCHER_OVERRUN_EN adds a sticky ovr output. It flags a
// new event that arrives while q is still high.
module stretcher #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 1,
  parameter int CNT_W          = 8
) (
  input  logic inp,
  input  logic clk,
  output logic q,
  input  logic rst_n
`ifdef STRETCHER_OVERRUN_EN
  ,
  output logic ovr
`endif
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH_CYCLES - 1);

  logic                   cap;
  logic                   cap_rst_n;
  logic [SYNC_STAGES-1:0] s;
  logic                   sp;
  logic                   start;
  logic [CNT_W-1:0]       cnt;

  // The clear from the synchronizer output dominates any inp edge.
  assign cap_rst_n = rst_n & ~s[SYNC_STAGES-1];

  // Edge-capture flop: inp is its clock, D is tied high.
  always_ff @(posedge inp or negedge cap_rst_n) begin
    if (!cap_rst_n) cap <= 1'b0;
    else            cap <= 1'b1;
  end

  // Synchronizer chain plus one delayed copy for edge detection.
  // Metastability settles in s[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s  <= '0;
      sp <= 1'b0;
    end else begin
      s  <= {s[SYNC_STAGES-2:0], cap};
      sp <= s[SYNC_STAGES-1];
    end
  end

  // Each synchronized event yields exactly one start strobe.
  assign start = s[SYNC_STAGES-1] & ~sp;

  // Stretch counter: a start reloads it, so q stays high with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      q   <= 1'b1;
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      q   <= 1'b0;
    end
  end

`ifdef STRETCHER_OVERRUN_EN
  // Sticky overrun flag: a start that lands while q is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ovr <= 1'b0;
    else if (start && q)   ovr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_stretcher.sv
`timescale 1ns/100ps
// Bench for stretcher: two instances share inp, clk and rst_n.
// Instance A uses the defaults (2 sync stages, 1-cycle stretch).
// Instance B uses 3 sync stages and an 8-cycle stretch, so retriggers overlap.
// The event model predicts each q pulse from the inp edge times. A monitor
// checks every observed q pulse against that prediction.
module tb_stretcher;
  localparam int NA = 2;
  localparam int SA = 1;
  localparam int NB = 3;
  localparam int SB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic inp   = 1'b0;
  logic q_a, q_b;
`ifdef STRETCHER_OVERRUN_EN
  logic ovr_a, ovr_b;
`endif

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  exp_rise [2][$];
  int  exp_end  [2][$];
  time free_time [2];
  bit  ovr_exp  [2];
  bit  abort_f  [2];
  bit  in_p     [2];
  int  rise_at  [2];
  int  nsync    [2] = '{NA, NB};
  int  nstr     [2] = '{SA, SB};

  stretcher #(.SYNC_STAGES(NA), .STRETCH_CYCLES(SA), .CNT_W(8)) u_a (
    .inp(inp), .clk(clk), .q(q_a), .rst_n(rst_n)
`ifdef STRETCHER_OVERRUN_EN
    , .ovr(ovr_a)
`endif
  );

  stretcher #(.SYNC_STAGES(NB), .STRETCH_CYCLES(SB), .CNT_W(8)) u_b (
    .inp(inp), .clk(clk), .q(q_b), .rst_n(rst_n)
`ifdef STRETCHER_OVERRUN_EN
    , .ovr(ovr_b)
`endif
  );

  // 100 ns clock, first rising edge at 50 ns.
  always #50 clk = ~clk;

  // cyc holds the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for one instance and one inp rising edge.
  // An edge is accepted only once the previous event's clear has dropped.
  // It is sampled at the next clk edge e. q then covers edges
  // e+N .. e+N+S-1, and the clear releases at edge e+2N-1.
  task automatic model_event(input int d);
    int e, s, en;
    if ($time >= free_time[d]) begin
      e  = cyc + 1;
      s  = e + nsync[d];
      en = s + nstr[d] - 1;
      free_time[d] = 50 + 100 * (e + 2 * nsync[d] - 2);
      if (exp_end[d].size() > 0 && exp_end[d][$] >= s - 1) begin
        exp_end[d][exp_end[d].size() - 1] = en;
        ovr_exp[d] = 1'b1;
      end else begin
        exp_rise[d].push_back(s);
        exp_end[d].push_back(en);
      end
    end
  endtask

  task automatic fire(input int w);
    inp = 1'b1;
    model_event(0);
    model_event(1);
    #(w);
    inp = 1'b0;
  endtask

  task automatic do_reset(input int len);
    rst_n = 1'b0;
    abort_f = '{1'b1, 1'b1};
    for (int d = 0; d < 2; d++) begin
      exp_rise[d].delete();
      exp_end[d].delete();
    end
    ovr_exp = '{1'b0, 1'b0};
    #1;
    check("reset_q_a", q_a, 0);
    check("reset_q_b", q_b, 0);
`ifdef STRETCHER_OVERRUN_EN
    check("reset_ovr_a", ovr_a, 0);
    check("reset_ovr_b", ovr_b, 0);
`endif
    #(len - 1);
    rst_n = 1'b1;
    free_time = '{0, 0};
  endtask

  // Monitor: find q pulses one time unit after each edge and score them.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      logic qv;
      qv = (d == 0) ? q_a : q_b;
      if (!rst_n) begin
        check("q_during_reset", qv, 0);
        in_p[d] = 1'b0;
      end else if (abort_f[d]) begin
        abort_f[d] = 1'b0;
        in_p[d] = qv;
        rise_at[d] = cyc;
      end else if (qv && !in_p[d]) begin
        in_p[d] = 1'b1;
        rise_at[d] = cyc;
      end else if (!qv && in_p[d]) begin
        in_p[d] = 1'b0;
        if (exp_rise[d].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse dut%0d: got edges %0d..%0d, expected none",
                   d, rise_at[d], cyc - 1);
        end else begin
          check($sformatf("pulse_rise_dut%0d", d), rise_at[d], exp_rise[d].pop_front());
          check($sformatf("pulse_end_dut%0d", d), cyc - 1, exp_end[d].pop_front());
        end
      end
    end
  end

  initial begin
    // Reset at time 0, released just before the first event at 1 ns.
    rst_n = 1'b0;
    #0.5;
    check("init_q_a", q_a, 0);
    check("init_q_b", q_b, 0);
    rst_n = 1'b1;
    free_time = '{0, 0};

    // Single pulse at 1 ns. A second pulse at 67 ns merges into the same event.
    #0.5;
    fire(6);
    #60;
    fire(6);
    #182;
    check("tp_q_a_high_250ns", q_a, 1);
    #100;
    check("tp_q_a_low_350ns", q_a, 0);
    repeat (12) @(posedge clk);

    // Burst of four pulses at 12 ns spacing.
    @(posedge clk);
    #10;
    repeat (4) begin
      fire(6);
      #6;
    end
    repeat (15) @(posedge clk);

    // Pulses every 66 ns, seven times. These retrigger the long stretch.
    @(posedge clk);
    #51;
    repeat (7) begin
      fire(6);
      #60;
    end
    repeat (15) @(posedge clk);
`ifdef STRETCHER_OVERRUN_EN
    check("ovr_a_after_train", ovr_a, ovr_exp[0]);
    check("ovr_b_after_train", ovr_b, ovr_exp[1]);
`endif

    // inp held high across several edges still counts as one event.
    @(posedge clk);
    #30;
    fire(450);
    repeat (15) @(posedge clk);

    // Random pulses: random gaps, offsets and widths.
    repeat (40) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      @(posedge clk);
      #($urandom_range(10, 80));
      fire($urandom_range(2, 8));
    end
    repeat (15) @(posedge clk);

    // Reset in the middle of a B stretch, then a fresh event.
    @(posedge clk);
    #20;
    fire(6);
    for (int i = 0; i < 20 && q_b !== 1'b1; i++) @(negedge clk);
    check("wait_q_b_high", q_b, 1);
    #10;
    do_reset(30);
    @(posedge clk);
    #20;
    fire(6);
    repeat (20) @(posedge clk);

    // Every predicted pulse must have appeared.
    check("pending_dut0", exp_rise[0].size(), 0);
    check("pending_dut1", exp_rise[1].size(), 0);
    check("open_pulse_dut0", in_p[0], 0);
    check("open_pulse_dut1", in_p[1], 0);
`ifdef STRETCHER_OVERRUN_EN
    check("ovr_a_final", ovr_a, ovr_exp[0]);
    check("ovr_b_final", ovr_b, ovr_exp[1]);
`else
    $display("note: modelled overlap flags a=%0d b=%0d", ovr_exp[0], ovr_exp[1]);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
